// File: rtl/seven_seg_pkg.sv
// Shared types and default sizing for the multiplexed
// seven-segment scanner.
package seven_seg_pkg;

    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam int DEF_NUM_DIGITS  = 8;
    localparam int DEF_REFRESH_CNT = 100000;
    localparam int DEF_GAP_CNT     = 16;

endpackage

// File: rtl/scan_timer.sv
// Shared dwell counter for the scanner; flags the last
// cycle of the current GAP or SHOW phase.
module scan_timer
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_CNT = DEF_REFRESH_CNT,
    parameter int GAP_CNT     = DEF_GAP_CNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic show,
    output logic gap_last,
    output logic show_last
);

    localparam int MAX_CNT =
        (REFRESH_CNT > GAP_CNT) ? REFRESH_CNT : GAP_CNT;
    localparam int CW = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

    logic [CW-1:0] cnt;

    assign gap_last  = !show && (cnt == CW'(GAP_CNT - 1));
    assign show_last = show && (cnt == CW'(REFRESH_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (gap_last || show_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed digit scanner with blanking gaps and
// frame-synchronous double buffering of the display data.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int REFRESH_CNT = DEF_REFRESH_CNT,
    parameter int GAP_CNT     = DEF_GAP_CNT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [3:0]              encoded,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           nidx;
    logic                    gap_last;
    logic                    show_last;
    logic                    wrap;

    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_en;
    logic [NUM_DIGITS-1:0]   act_dp;

    logic [4*NUM_DIGITS-1:0] next_value;
    logic [NUM_DIGITS-1:0]   next_en;
    logic [NUM_DIGITS-1:0]   next_dp;
    logic [NUM_DIGITS-1:0]   show_anode;

    scan_timer #(
        .REFRESH_CNT (REFRESH_CNT),
        .GAP_CNT     (GAP_CNT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .show      (state == SHOW),
        .gap_last  (gap_last),
        .show_last (show_last)
    );

    // next_* is what the active copy holds after this edge;
    // a load on the wrap edge bypasses the pending copy.
    always_comb begin
        wrap       = show_last && (idx == LAST);
        nidx       = wrap ? '0 : idx + IW'(1);
        next_value = act_value;
        next_en    = act_en;
        next_dp    = act_dp;
        if (wrap) begin
            if (load) begin
                next_value = value;
                next_en    = digit_en;
                next_dp    = dp_in;
            end else begin
                next_value = pend_value;
                next_en    = pend_en;
                next_dp    = pend_dp;
            end
        end
        show_anode = '1;
        if (act_en[idx]) begin
            show_anode[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= GAP;
            idx        <= '0;
            anode      <= '1;
            encoded    <= 4'h0;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
            pend_value <= '0;
            pend_en    <= '0;
            pend_dp    <= '0;
            act_value  <= '0;
            act_en     <= '0;
            act_dp     <= '0;
        end else begin
            frame_done <= wrap;
            if (load) begin
                pend_value <= value;
                pend_en    <= digit_en;
                pend_dp    <= dp_in;
            end
            if (wrap) begin
                act_value <= next_value;
                act_en    <= next_en;
                act_dp    <= next_dp;
            end
            unique case (state)
                GAP: begin
                    if (gap_last) begin
                        state <= SHOW;
                        anode <= show_anode;
                    end
                end
                SHOW: begin
                    if (show_last) begin
                        state   <= GAP;
                        anode   <= '1;
                        idx     <= nidx;
                        encoded <= next_value[{nidx, 2'b00} +: 4];
                        dp_n    <= ~next_dp[nidx];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized bench for seven_seg_scan against a frame-time
// model derived from the cycle count since reset.
module tb_seven_seg_scan;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int G  = 2;
    localparam int DP = G + R;
    localparam int FP = N * DP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  encoded;
    logic        dp_n;
    logic [3:0]  anode;
    logic        frame_done;

    seven_seg_scan #(
        .NUM_DIGITS  (N),
        .REFRESH_CNT (R),
        .GAP_CNT     (G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .encoded    (encoded),
        .dp_n       (dp_n),
        .anode      (anode),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: time since reset plus pending/active data sets.
    int          t = 0;
    logic [15:0] m_pv = '0;
    logic [15:0] m_av = '0;
    logic [3:0]  m_pe = '0;
    logic [3:0]  m_ae = '0;
    logic [3:0]  m_pd = '0;
    logic [3:0]  m_ad = '0;

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)",
                     tag, got, exp, t);
        end
    endtask

    task automatic model_edge();
        if ((t % FP) == FP - 1) begin
            if (load) begin
                m_av = value;
                m_ae = digit_en;
                m_ad = dp_in;
            end else begin
                m_av = m_pv;
                m_ae = m_pe;
                m_ad = m_pd;
            end
        end
        if (load) begin
            m_pv = value;
            m_pe = digit_en;
            m_pd = dp_in;
        end
        t++;
    endtask

    task automatic check_outputs();
        int         p;
        int         d;
        logic [3:0] ea;
        p  = t % FP;
        d  = p / DP;
        ea = 4'hF;
        if ((p % DP) >= G && m_ae[d]) ea[d] = 1'b0;
        chk("anode", anode, ea);
        chk("encoded", encoded, m_av[d*4 +: 4]);
        chk("dp_n", dp_n, !m_ad[d]);
        chk("frame_done", frame_done, (p == 0 && t > 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        load = 1'b0;
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    task automatic run_to_last();
        while ((t % FP) != FP - 1) tick();
    endtask

    task automatic do_load(logic [15:0] v, logic [3:0] e,
                           logic [3:0] d);
        load     = 1'b1;
        value    = v;
        digit_en = e;
        dp_in    = d;
    endtask

    // Entered at a negedge; drops reset mid-cycle and
    // attempts a load while reset is held.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_anode", anode, 4'hF);
        chk("rst_encoded", encoded, 4'h0);
        chk("rst_dp_n", dp_n, 1'b1);
        chk("rst_frame_done", frame_done, 1'b0);
        do_load(16'($urandom), 4'hF, 4'hF);
        repeat (2) @(negedge clk);
        chk("rst_hold_anode", anode, 4'hF);
        load  = 1'b0;
        rst_n = 1'b1;
        t    = 0;
        m_pv = '0;
        m_av = '0;
        m_pe = '0;
        m_ae = '0;
        m_pd = '0;
        m_ad = '0;
        check_outputs();
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        run(3 * FP);

        run(5);
        do_load(16'h3A51, 4'hF, 4'b0010);
        tick();
        run_to_last();
        tick();
        run(FP);

        do_load(16'h3A51, 4'b1011, 4'b0000);
        tick();
        run_to_last();
        tick();
        run(FP);

        run(7);
        do_load(16'h1111, 4'hF, 4'b0000);
        tick();
        run(5);
        do_load(16'h2222, 4'hF, 4'b0000);
        tick();
        run_to_last();
        tick();
        run(FP);

        run_to_last();
        do_load(16'hBEEF, 4'hF, 4'b0001);
        tick();
        chk("bypass_d0", encoded, 4'hF);
        run(FP);

        repeat (300) begin
            if ($urandom_range(0, 9) == 0)
                do_load(16'($urandom), 4'($urandom),
                        4'($urandom));
            tick();
        end

        do_load(16'h7654, 4'hF, 4'b0100);
        tick();
        run_to_last();
        tick();
        while ((t % FP) != 2 * DP + G + 1) tick();
        chk("pre_rst_anode", anode, 4'b1011);
        do_reset();
        run(2 * FP);
        do_load(16'h0C9D, 4'b0111, 4'b1001);
        tick();
        run_to_last();
        tick();
        run(FP);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8: digits scanned, 2..8.
REQ-002 SHALL have parameter REFRESH_CNT, default 100000: clk cycles per digit lit (SHOW), >=2.
REQ-003 SHALL have parameter GAP_CNT, default 16: clk cycles all anodes off between digits (GAP), >=1.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load  input  1  one-cycle strobe capturing value/digit_en/dp_in.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i].
REQ-008 SHALL have port digit_en  input  NUM_DIGITS  per-digit enable; 0 = digit blanked.
REQ-009 SHALL have port dp_in  input  NUM_DIGITS  per-digit decimal point, 1 = lit.
REQ-010 SHALL have port encoded  output  4  registered nibble of current digit, for the downstream segment decoder.
REQ-011 SHALL have port dp_n  output  1  registered decimal point, active-low.
REQ-012 SHALL have port anode  output  NUM_DIGITS  registered digit select, active-low, at most one bit low.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse per completed scan.

Function
REQ-014 SHALL hold pending and active copies of value, digit_en and dp_in; load writes pending; a load while pending is unapplied overwrites it.
REQ-015 SHALL implement FSM states GAP and SHOW with one shared cycle counter cnt and digit index idx.
REQ-016 GAP: all anode bits 1; cnt==GAP_CNT-1 -> SHOW, cnt cleared.
REQ-017 SHOW: anode[idx]=0 if active digit_en[idx]=1, else all 1; cnt==REFRESH_CNT-1 -> GAP, cnt cleared, idx advances.
REQ-018 idx SHALL advance modulo NUM_DIGITS; NUM_DIGITS-1 wraps to 0.
REQ-019 On the SHOW->GAP edge, encoded and dp_n SHALL load the new idx's nibble and inverted dp, so encoded is stable >=GAP_CNT cycles before its anode asserts (covers one-cycle decoder latency).
REQ-020 On the wrapping edge, active SHALL take pending; if load is high that same cycle, active takes the load-cycle inputs directly (bypass), and encoded/dp_n for digit 0 use the new active data.
REQ-021 Active contents SHALL never change except on the wrapping edge (no mid-frame tearing).
REQ-022 frame_done SHALL be 1 for exactly the first GAP cycle after each wrap, never after reset.
REQ-023 Digit period SHALL be GAP_CNT+REFRESH_CNT cycles; frame period NUM_DIGITS times that.
REQ-024 anode, encoded, dp_n, frame_done SHALL be flop outputs, no combinational path from inputs.

Reset
REQ-025 rst_n low SHALL asynchronously force: state GAP, cnt 0, idx 0, anode all 1, encoded 0, dp_n 1, frame_done 0, pending and active registers all 0 (display blank).
REQ-026 Reset release mid-scan SHALL restart at GAP, idx 0; a load during reset SHALL be ignored.

Structure
REQ-027 Package seven_seg_pkg SHALL hold the state enum (GAP, SHOW) and default NUM_DIGITS/REFRESH_CNT/GAP_CNT constants.
REQ-028 Sub-module scan_timer SHALL own cnt and the terminal-count flags for GAP/SHOW; FSM, idx, shadow registers stay in seven_seg_scan.

Verification (NUM_DIGITS=4, REFRESH_CNT=4, GAP_CNT=2)
REQ-029 Reset then no load -> anode stays 4'b1111 for 3 frames, encoded 0, dp_n 1, frame_done pulses every 24 cycles.
REQ-030 load value=16'h3A51, digit_en=4'hF, dp_in=4'b0010 -> after next wrap, encoded sequence 1,5,A,3; dp_n=0 only with idx 1; each anode low exactly 4 cycles, 2 all-high cycles between.
REQ-031 digit_en=4'b1011 -> anode[2] never low; idx 2 slot still takes 6 cycles; encoded still presents nibble 2.
REQ-032 load 16'h1111 mid-frame then load 16'h2222 before wrap -> current frame unchanged; next frame shows only 2; 1 never displayed.
REQ-033 load 16'hBEEF coincident with wrap edge -> digit 0 of new frame shows F immediately.
REQ-034 rst_n pulsed low mid-SHOW of idx 2 -> anode 4'b1111 same cycle (async), restart at idx 0, display blank until next load plus wrap.
